// File: rtl/lcd_pkg.sv
// Shared constants for the LCD1602 text path: geometry, pad character,
// display-mode codes, control bytes and the line-buffer FSM states.
package lcd_pkg;

   localparam int         COLS     = 16;
   localparam logic [7:0] PAD_CHAR = 8'h20;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_BLINK  = 2'b01;
   localparam logic [1:0] MODE_FLASH  = 2'b10;

   localparam logic [7:0] CMD_BS  = 8'h08;
   localparam logic [7:0] CMD_LF  = 8'h0A;
   localparam logic [7:0] CMD_CLR = 8'h0C;
   localparam logic [7:0] CMD_CR  = 8'h0D;
   localparam logic [7:0] CMD_M0  = 8'h11;
   localparam logic [7:0] CMD_M1  = 8'h12;
   localparam logic [7:0] CMD_M2  = 8'h13;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COPY,
      S_CLEAR
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20) && (b <= 8'h7E);
   endfunction

endpackage

// File: rtl/lcd_text_buffer.sv
// Assembles one LCD line from a serial byte stream in a back buffer and
// commits it column by column to the display buffer read by the LCD driver.
module lcd_text_buffer #(
   parameter int         COLS     = lcd_pkg::COLS,
   parameter logic [7:0] PAD_CHAR = lcd_pkg::PAD_CHAR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     rx_ready,
   input  logic [$clog2(COLS)-1:0]  rd_addr,
   output logic [7:0]               rd_data,
   output logic [1:0]               mode,
   output logic                     line_updated,
   output logic                     overflow
);

   import lcd_pkg::*;

   localparam int              AW       = $clog2(COLS);
   localparam int              WPW      = AW + 1;
   localparam logic [WPW-1:0]  WP_FULL  = WPW'(COLS);
   localparam logic [AW-1:0]   IDX_LAST = AW'(COLS - 1);

   logic [7:0]     back [COLS];
   logic [7:0]     disp [COLS];
   logic [WPW-1:0] wp;
   logic [AW-1:0]  idx;
   state_t         state;

   logic [AW-1:0]  wp_lo;
   logic [AW-1:0]  wp_prev;
   logic           xfer;

   assign wp_lo    = wp[AW-1:0];
   assign wp_prev  = wp_lo - AW'(1);
   assign rx_ready = (state == S_IDLE);
   assign xfer     = rx_valid & rx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         wp           <= '0;
         idx          <= '0;
         mode         <= MODE_NORMAL;
         line_updated <= 1'b0;
         overflow     <= 1'b0;
         rd_data      <= PAD_CHAR;
         // NOTE: both buffers must come out of reset as blank text, so these
         // arrays are reset as flops rather than inferred as RAM.
         for (int i = 0; i < COLS; i++) begin
            back[i] <= PAD_CHAR;
            disp[i] <= PAD_CHAR;
         end
      end else begin
         line_updated <= 1'b0;
         rd_data      <= disp[rd_addr];

         case (state)
            S_IDLE: begin
               if (xfer) begin
                  if (is_printable(rx_data)) begin
                     if (wp < WP_FULL) begin
                        back[wp_lo] <= rx_data;
                        wp          <= wp + WPW'(1);
                     end else begin
                        overflow <= 1'b1;
                     end
                  end else begin
                     case (rx_data)
                        CMD_BS: begin
                           if (wp != '0) begin
                              wp            <= wp - WPW'(1);
                              back[wp_prev] <= PAD_CHAR;
                           end
                        end
                        CMD_CR, CMD_LF: begin
                           state <= S_COPY;
                           idx   <= '0;
                        end
                        CMD_CLR: begin
                           state <= S_CLEAR;
                           idx   <= '0;
                        end
                        CMD_M0:  mode <= MODE_NORMAL;
                        CMD_M1:  mode <= MODE_BLINK;
                        CMD_M2:  mode <= MODE_FLASH;
                        default: ;
                     endcase
                  end
               end
            end

            // Columns past wp already hold PAD_CHAR, so a straight copy suffices.
            S_COPY: begin
               disp[idx] <= back[idx];
               idx       <= idx + AW'(1);
               if (idx == IDX_LAST) begin
                  state        <= S_CLEAR;
                  line_updated <= 1'b1;
               end
            end

            S_CLEAR: begin
               back[idx] <= PAD_CHAR;
               idx       <= idx + AW'(1);
               if (idx == IDX_LAST) begin
                  state    <= S_IDLE;
                  wp       <= '0;
                  overflow <= 1'b0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
